// File: rtl/eros_obi_arbiter.sv
// eros_obi_arbiter: round-robin arbiter that shares one OBI RAM bank among
// NREQ requesters, with at most one outstanding bank transaction.
// Optional starvation monitor enabled by defining EROS_ARB_STARVE_MON_EN.
//
// state | meaning
// IDLE  | no outstanding transaction, issue window open
// BUSY  | one transaction granted, waiting for s_rvalid_i
module eros_obi_arbiter #(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       m_req_i,
  input  logic [NREQ-1:0][31:0] m_addr_i,
  input  logic [NREQ-1:0][31:0] m_wdata_i,
  input  logic [NREQ-1:0]       m_we_i,
  input  logic [NREQ-1:0][3:0]  m_be_i,
  output logic [NREQ-1:0]       m_gnt_o,
  output logic [NREQ-1:0]       m_rvalid_o,
  output logic [31:0]           m_rdata_o,
  output logic                  s_req_o,
  output logic [31:0]           s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_rdata_i,
  output logic [NREQ-1:0]       starve_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] last_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic          found;
  logic          issue_win;
  logic          handshake;
  int            scan_idx;

  // The issue window is also open on the closing rvalid cycle so that
  // back-to-back transactions need no idle bank cycle.
  assign issue_win = !rst_i && ((state == IDLE) || s_rvalid_i);
  assign s_req_o   = issue_win && found;
  assign handshake = s_req_o && s_gnt_i;
  assign m_rdata_o = s_rdata_i;

  // Rotating-priority scan starting just after the last granted index.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = int'(last_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && m_req_i[scan_idx]) begin
        found  = 1'b1;
        winner = PW'(scan_idx);
      end
    end
  end

  // Bank-side request fields mirror the winner; zero when not requesting.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_addr_o  = m_addr_i[winner];
      s_we_o    = m_we_i[winner];
      s_be_o    = m_be_i[winner];
      s_wdata_o = m_wdata_i[winner];
    end
  end

  // Grant and response steering back to the requesters.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (s_req_o) m_gnt_o[winner] = s_gnt_i;
    if (!rst_i && (state == BUSY) && s_rvalid_i) m_rvalid_o[owner] = 1'b1;
  end

  // Transaction state, round-robin pointer and current owner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_ptr <= PW'(NREQ - 1);
      owner    <= '0;
    end else if (handshake) begin
      state    <= BUSY;
      last_ptr <= winner;
      owner    <= winner;
    end else if ((state == BUSY) && s_rvalid_i) begin
      state <= IDLE;
    end
  end

`ifdef EROS_ARB_STARVE_MON_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]      wait_cnt [NREQ];
  logic [NREQ-1:0] waiting;

  assign waiting = m_req_i & ~m_gnt_o;

  // Per-requester wait counters; saturate at the limit until cleared.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst_i || !waiting[i]) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != LIM) begin
        wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
    end
  end

  // Pulse on the waiting cycle in which the counter reaches the limit.
  always_comb begin
    starve_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      starve_o[i] = !rst_i && waiting[i] && (wait_cnt[i] != LIM) &&
                    ((wait_cnt[i] + 4'd1) == LIM);
    end
  end
`else
  assign starve_o = '0;
`endif

endmodule

// File: tb/tb_eros_obi_arbiter.sv
// Directed bench for eros_obi_arbiter (NREQ=4): a per-cycle vector table
// covers rotation, back-to-back, single requester, stalled grant, reset
// while busy and stray rvalid; a hand-written sequence covers starvation.
module tb_eros_obi_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       m_req;
  logic [3:0][31:0] m_addr;
  logic [3:0][31:0] m_wdata;
  logic [3:0]       m_we;
  logic [3:0][3:0]  m_be;
  logic [3:0]       m_gnt;
  logic [3:0]       m_rvalid;
  logic [31:0]      m_rdata;
  logic             s_req;
  logic [31:0]      s_addr;
  logic             s_we;
  logic [3:0]       s_be;
  logic [31:0]      s_wdata;
  logic             s_gnt;
  logic             s_rvalid;
  logic [31:0]      s_rdata;
  logic [3:0]       starve;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eros_obi_arbiter #(.NREQ(4), .STARVE_LIMIT(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_we_i(m_we), .m_be_i(m_be),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
    .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .starve_o(starve)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       sgnt;
    logic       srv;
    logic [3:0] egnt;
    logic [3:0] erv;
    logic       esreq;
    logic [1:0] ewin;
  } vec_t;

  vec_t vecs[$];

  // Requester field table (requester 2 carries the mirrored-write values).
  logic [31:0] addr_t  [4] = '{32'h1000_0000, 32'h1000_0020, 32'h1000_0040, 32'h1000_0060};
  logic [31:0] wdata_t [4] = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
  logic        we_t    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0]  be_t    [4] = '{4'h1, 4'h3, 4'hF, 4'h8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic g, input logic v,
                     input logic [3:0] eg, input logic [3:0] ev, input logic es,
                     input logic [1:0] ew);
    vec_t t;
    t = '{rst: r, req: q, sgnt: g, srv: v, egnt: eg, erv: ev, esreq: es, ewin: ew};
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int first_pulse;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_addr[i]  = addr_t[i];
      m_wdata[i] = wdata_t[i];
      m_we[i]    = we_t[i];
      m_be[i]    = be_t[i];
    end
    rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;

    //   rst req     gnt rv   egnt     erv      sreq win
    add(1, 4'b1111, 1, 1, 4'b0000, 4'b0000, 0, 0); // in reset, all gated
    add(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 0); // first grant to 0
    add(0, 4'b1111, 1, 1, 4'b0010, 4'b0001, 1, 1); // back-to-back
    add(0, 4'b1111, 1, 1, 4'b0100, 4'b0010, 1, 2);
    add(0, 4'b1111, 1, 1, 4'b1000, 4'b0100, 1, 3);
    add(0, 4'b1111, 1, 1, 4'b0001, 4'b1000, 1, 0); // wraps to 0
    add(0, 4'b0000, 1, 1, 4'b0000, 4'b0001, 0, 0); // close, go IDLE
    add(0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0); // stray rvalid in IDLE
    add(0, 4'b0100, 1, 0, 4'b0100, 4'b0000, 1, 2); // single requester 2
    add(0, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 2); // re-granted each window
    add(0, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 2);
    add(0, 4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 2); // BUSY, window closed
    add(0, 4'b0000, 0, 1, 4'b0000, 4'b0100, 0, 0); // close to IDLE, last=2
    add(0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 1, 1); // stalled grant x3
    add(0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0010, 1, 0, 4'b0010, 4'b0000, 1, 1); // grant when s_gnt rises
    add(0, 4'b1001, 1, 1, 4'b1000, 4'b0010, 1, 3); // last=1 -> 3 before 0
    add(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0); // reset while busy
    add(0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0); // late rvalid ignored
    add(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 0); // 0 wins first again
    add(0, 4'b0010, 0, 1, 4'b0000, 4'b0001, 1, 1); // window, no handshake
    add(0, 4'b0100, 1, 0, 4'b0100, 4'b0000, 1, 2); // 1 dropped, 2 wins

    tick();
    for (int v = 0; v < vecs.size(); v++) begin
      rst      = vecs[v].rst;
      m_req    = vecs[v].req;
      s_gnt    = vecs[v].sgnt;
      s_rvalid = vecs[v].srv;
      s_rdata  = 32'h1234_5678 + 32'(v);
      #1;
      chk($sformatf("v%0d m_gnt", v), 32'(m_gnt), 32'(vecs[v].egnt));
      chk($sformatf("v%0d m_rvalid", v), 32'(m_rvalid), 32'(vecs[v].erv));
      chk($sformatf("v%0d s_req", v), 32'(s_req), 32'(vecs[v].esreq));
      chk($sformatf("v%0d m_rdata", v), m_rdata, 32'h1234_5678 + 32'(v));
      if (vecs[v].esreq) begin
        chk($sformatf("v%0d s_addr", v), s_addr, addr_t[vecs[v].ewin]);
        chk($sformatf("v%0d s_wdata", v), s_wdata, wdata_t[vecs[v].ewin]);
        chk($sformatf("v%0d s_we", v), 32'(s_we), 32'(we_t[vecs[v].ewin]));
        chk($sformatf("v%0d s_be", v), 32'(s_be), 32'(be_t[vecs[v].ewin]));
      end
      if (vecs[v].rst) begin
        chk($sformatf("v%0d rst s_addr", v), s_addr, 32'h0);
        chk($sformatf("v%0d rst s_wdata", v), s_wdata, 32'h0);
        chk($sformatf("v%0d rst s_we_be", v), {27'h0, s_we, s_be}, 32'h0);
      end
      tick();
    end

    // Explicit mirror of requester 2's write onto the bank port.
    rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    tick();
    rst = 1'b0; m_req = 4'b0100; s_gnt = 1'b1;
    #1;
    chk("req2 s_addr", s_addr, 32'h1000_0040);
    chk("req2 s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("req2 s_we_be", {27'h0, s_we, s_be}, {27'h0, 1'b1, 4'hF});
    chk("req2 m_gnt", 32'(m_gnt), 32'b0100);
    tick();

    // Starvation: requester 0 waits 20 cycles with the bank refusing grants.
    rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    tick();
    rst = 1'b0; m_req = 4'b0001;
    pulses = 0;
    first_pulse = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (starve[0]) begin
        pulses++;
        if (first_pulse == 0) first_pulse = c;
      end
      if (starve[3:1] != 3'b000) begin
        errors++;
        $display("FAIL starve_other actual=%b required=000 cycle=%0d", starve[3:1], c);
      end
      if (m_gnt != 4'b0000) begin
        errors++;
        $display("FAIL starve_gnt actual=%b required=0000 cycle=%0d", m_gnt, c);
      end
      tick();
    end
`ifdef EROS_ARB_STARVE_MON_EN
    chk("starve pulses", 32'(pulses), 32'd1);
    chk("starve cycle", 32'(first_pulse), 32'd15);
`else
    chk("starve pulses", 32'(pulses), 32'd0);
`endif
    s_gnt = 1'b1;
    #1;
    chk("starve release gnt", 32'(m_gnt), 32'b0001);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
